mb8_cpa_check: RTL and testbench

- Downstream stage of the 8x8 radix-4 signed Booth multiplier (mb8_top).
- Takes its carry-save pair (sum, carry), 16 bits each, and resolves it to the final 16-bit two's-complement product.
- The resolve is a 2-stage pipelined split carry-propagate adder: low half, then high half.
- In parallel, it checks each product against a behavioural signed multiply of the operands, and keeps an error flag and saturating counters for on-chip self-test.

---
 rtl/mb8_cpa_check_if.sv | 29 ++
 rtl/mb8_cpa_check.sv | 116 +++++++++++
 tb/tb_mb8_cpa_check.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mb8_cpa_check_if.sv
// Sample bus between the Booth multiplier and the CPA/check stage.
// The driver side owns the sample inputs and clear; the stage owns the results.
interface mb8_cpa_check_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic                 in_valid;
    logic [2*WIDTH-1:0]   sum_in;
    logic [2*WIDTH-1:0]   carry_in;
    logic [WIDTH-1:0]     mx_in;
    logic [WIDTH-1:0]     my_in;
    logic                 clr_err;
    logic [2*WIDTH-1:0]   prod;
    logic                 out_valid;
    logic                 mismatch;
    logic                 err_sticky;
    logic [CNT_W-1:0]     err_cnt;
    logic [CNT_W-1:0]     smp_cnt;

    modport master (
        output in_valid, sum_in, carry_in, mx_in, my_in, clr_err,
        input  prod, out_valid, mismatch, err_sticky, err_cnt, smp_cnt
    );

    modport slave (
        input  in_valid, sum_in, carry_in, mx_in, my_in, clr_err,
        output prod, out_valid, mismatch, err_sticky, err_cnt, smp_cnt
    );
endinterface

// File: rtl/mb8_cpa_check.sv
// Two-stage split carry-propagate adder resolving the Booth carry-save pair,
// with a behavioural product check, sticky error flag and saturating counters.
module mb8_cpa_check #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic CLK,
    input logic RST,
    mb8_cpa_check_if.slave bus
);
    localparam int PW = 2 * WIDTH;

    logic [WIDTH-1:0] lo_q, lo_d;
    logic             c1_q, c1_d;
    logic [WIDTH-1:0] hi_s_q, hi_s_d;
    logic [WIDTH-1:0] hi_c_q, hi_c_d;
    logic [WIDTH-1:0] mx_q, mx_d;
    logic [WIDTH-1:0] my_q, my_d;
    logic             v1_q, v1_d;

    logic [PW-1:0]    prod_q, prod_d;
    logic             mism_q, mism_d;
    logic             ov_q, ov_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;

    logic [PW-1:0]    sum2;
    logic [PW-1:0]    ref2;
    logic             bad2;

    always_comb begin
        lo_d   = lo_q;
        c1_d   = c1_q;
        hi_s_d = hi_s_q;
        hi_c_d = hi_c_q;
        mx_d   = mx_q;
        my_d   = my_q;
        v1_d   = bus.in_valid;
        if (bus.in_valid) begin
            {c1_d, lo_d} = {1'b0, bus.sum_in[WIDTH-1:0]}
                         + {1'b0, bus.carry_in[WIDTH-1:0]};
            hi_s_d = bus.sum_in[PW-1:WIDTH];
            hi_c_d = bus.carry_in[PW-1:WIDTH];
            mx_d   = bus.mx_in;
            my_d   = bus.my_in;
        end
    end

    // Sign-extended operands multiplied in 2*WIDTH bits give the signed low product.
    always_comb begin
        sum2 = {hi_s_q + hi_c_q + WIDTH'(c1_q), lo_q};
        ref2 = {{WIDTH{mx_q[WIDTH-1]}}, mx_q}
             * {{WIDTH{my_q[WIDTH-1]}}, my_q};
        bad2 = v1_q && (sum2 != ref2);
    end

    always_comb begin
        prod_d = v1_q ? sum2 : prod_q;
        mism_d = v1_q ? bad2 : mism_q;
        ov_d   = v1_q;
        err_d  = err_q;
        ecnt_d = ecnt_q;
        scnt_d = scnt_q;
        if (bus.clr_err) begin
            err_d  = 1'b0;
            ecnt_d = '0;
            scnt_d = '0;
        end else if (v1_q) begin
            if (!(&scnt_q)) scnt_d = scnt_q + CNT_W'(1);
            if (bad2) begin
                err_d = 1'b1;
                if (!(&ecnt_q)) ecnt_d = ecnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lo_q   <= '0;
            c1_q   <= 1'b0;
            hi_s_q <= '0;
            hi_c_q <= '0;
            mx_q   <= '0;
            my_q   <= '0;
            v1_q   <= 1'b0;
            prod_q <= '0;
            mism_q <= 1'b0;
            ov_q   <= 1'b0;
            err_q  <= 1'b0;
            ecnt_q <= '0;
            scnt_q <= '0;
        end else begin
            lo_q   <= lo_d;
            c1_q   <= c1_d;
            hi_s_q <= hi_s_d;
            hi_c_q <= hi_c_d;
            mx_q   <= mx_d;
            my_q   <= my_d;
            v1_q   <= v1_d;
            prod_q <= prod_d;
            mism_q <= mism_d;
            ov_q   <= ov_d;
            err_q  <= err_d;
            ecnt_q <= ecnt_d;
            scnt_q <= scnt_d;
        end
    end

    assign bus.prod       = prod_q;
    assign bus.mismatch   = mism_q;
    assign bus.out_valid  = ov_q;
    assign bus.err_sticky = err_q;
    assign bus.err_cnt    = ecnt_q;
    assign bus.smp_cnt    = scnt_q;
endmodule

// File: tb/tb_mb8_cpa_check.sv
// Randomised and directed bench for mb8_cpa_check.
// Expected results come from a delay-line model using plain signed arithmetic.
module tb_mb8_cpa_check;
    logic CLK;
    logic RST;
    int   total;
    int   bad;

    mb8_cpa_check_if #(.WIDTH(8), .CNT_W(8)) bus ();

    mb8_cpa_check #(.WIDTH(8), .CNT_W(8)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        d_v;
    logic [15:0] d_s, d_c;
    logic [7:0]  d_x, d_y;
    logic [15:0] m_prod;
    logic        m_mm, m_ov, m_err;
    logic [7:0]  m_ecnt, m_scnt;

    task automatic model_reset();
        d_v = 0; d_s = 0; d_c = 0; d_x = 0; d_y = 0;
        m_prod = 0; m_mm = 0; m_ov = 0; m_err = 0;
        m_ecnt = 0; m_scnt = 0;
    endtask

    task automatic drive_idle();
        bus.in_valid = 0; bus.sum_in = 0; bus.carry_in = 0;
        bus.mx_in = 0; bus.my_in = 0; bus.clr_err = 0;
    endtask

    // Starts and ends at a falling edge; one rising edge in between.
    task automatic cycle(input bit v, input logic [15:0] s, input logic [15:0] c,
                         input logic [7:0] x, input logic [7:0] y, input bit clr);
        int p;
        bus.in_valid = v; bus.sum_in = s; bus.carry_in = c;
        bus.mx_in = x; bus.my_in = y; bus.clr_err = clr;
        @(posedge CLK);
        if (d_v) begin
            m_prod = d_s + d_c;
            p = $signed(d_x) * $signed(d_y);
            m_mm = (m_prod != p[15:0]);
        end
        m_ov = d_v;
        if (clr) begin
            m_err = 0; m_ecnt = 0; m_scnt = 0;
        end else if (d_v) begin
            if (m_scnt != 8'hFF) m_scnt = m_scnt + 8'd1;
            if (m_mm) begin
                m_err = 1;
                if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
            end
        end
        d_v = v; d_s = s; d_c = c; d_x = x; d_y = y;
        @(negedge CLK);
    endtask

    task automatic gen(input bit wrong, output logic [15:0] s, output logic [15:0] c,
                       output logic [7:0] x, output logic [7:0] y);
        int p;
        logic [15:0] t;
        x = 8'($urandom); y = 8'($urandom);
        p = $signed(x) * $signed(y);
        t = p[15:0];
        if (wrong) t = t ^ 16'(1 + $urandom_range(0, 65534));
        s = 16'($urandom);
        c = t - s;
    endtask

    task automatic test_reset();
        RST = 0;
        drive_idle();
        model_reset();
        #12;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_ov got=%b want=0", bus.out_valid); end
        total++; if (bus.prod !== 16'h0) begin bad++; $display("FAIL rst_prod got=%h want=0000", bus.prod); end
        total++; if (bus.mismatch !== 1'b0) begin bad++; $display("FAIL rst_mm got=%b want=0", bus.mismatch); end
        total++; if (bus.err_sticky !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", bus.err_sticky); end
        total++; if (bus.err_cnt !== 8'h0) begin bad++; $display("FAIL rst_ecnt got=%0d want=0", bus.err_cnt); end
        total++; if (bus.smp_cnt !== 8'h0) begin bad++; $display("FAIL rst_scnt got=%0d want=0", bus.smp_cnt); end
        @(negedge CLK);
        RST = 1;
        @(negedge CLK);
    endtask

    task automatic test_directed();
        logic [15:0] ts [4] = '{16'h000F, 16'h3FFF, 16'hFFFF, 16'h0001};
        logic [15:0] tc [4] = '{16'h0000, 16'h0001, 16'hC081, 16'h0000};
        logic [7:0]  tx [4] = '{8'd3, 8'h80, 8'h80, 8'd2};
        logic [7:0]  ty [4] = '{8'd5, 8'h80, 8'd127, 8'd3};
        logic [15:0] tp [4] = '{16'h000F, 16'h4000, 16'hC080, 16'h0001};
        bit          tm [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            cycle(1, ts[i], tc[i], tx[i], ty[i], 0);
            cycle(0, 0, 0, 0, 0, 0);
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL dir%0d_ov got=%b want=1", i, bus.out_valid); end
            total++; if (bus.prod !== tp[i]) begin bad++; $display("FAIL dir%0d_prod got=%h want=%h", i, bus.prod, tp[i]); end
            total++; if (bus.mismatch !== tm[i]) begin bad++; $display("FAIL dir%0d_mm got=%b want=%b", i, bus.mismatch, tm[i]); end
            total++; if (bus.smp_cnt !== m_scnt) begin bad++; $display("FAIL dir%0d_scnt got=%0d want=%0d", i, bus.smp_cnt, m_scnt); end
            total++; if (bus.err_cnt !== m_ecnt) begin bad++; $display("FAIL dir%0d_ecnt got=%0d want=%0d", i, bus.err_cnt, m_ecnt); end
            total++; if (bus.err_sticky !== m_err) begin bad++; $display("FAIL dir%0d_err got=%b want=%b", i, bus.err_sticky, m_err); end
        end
        total++; if (bus.smp_cnt !== 8'd4) begin bad++; $display("FAIL dir_scnt4 got=%0d want=4", bus.smp_cnt); end
        total++; if (bus.err_cnt !== 8'd1) begin bad++; $display("FAIL dir_ecnt1 got=%0d want=1", bus.err_cnt); end
    endtask

    task automatic test_clear_priority();
        cycle(1, 16'h0001, 16'h0000, 8'd2, 8'd3, 0);
        cycle(0, 0, 0, 0, 0, 1);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL clr_ov got=%b want=1", bus.out_valid); end
        total++; if (bus.mismatch !== 1'b1) begin bad++; $display("FAIL clr_mm got=%b want=1", bus.mismatch); end
        total++; if (bus.err_sticky !== 1'b0) begin bad++; $display("FAIL clr_err got=%b want=0", bus.err_sticky); end
        total++; if (bus.err_cnt !== 8'd0) begin bad++; $display("FAIL clr_ecnt got=%0d want=0", bus.err_cnt); end
        total++; if (bus.smp_cnt !== 8'd0) begin bad++; $display("FAIL clr_scnt got=%0d want=0", bus.smp_cnt); end
    endtask

    task automatic test_saturation();
        logic [15:0] s, c;
        logic [7:0]  x, y;
        bit          want;
        for (int i = 0; i < 302; i++) begin
            if (i < 300) begin
                gen(1, s, c, x, y);
                cycle(1, s, c, x, y, 0);
            end else begin
                cycle(0, 0, 0, 0, 0, 0);
            end
            want = (i >= 1) && (i <= 300);
            total++; if (bus.out_valid !== want) begin bad++; $display("FAIL sat_ov cyc=%0d got=%b want=%b", i + 1, bus.out_valid, want); end
            total++; if (bus.err_cnt !== m_ecnt) begin bad++; $display("FAIL sat_ecnt cyc=%0d got=%0d want=%0d", i + 1, bus.err_cnt, m_ecnt); end
        end
        total++; if (bus.err_cnt !== 8'hFF) begin bad++; $display("FAIL sat_ecnt_end got=%0d want=255", bus.err_cnt); end
        total++; if (bus.smp_cnt !== 8'hFF) begin bad++; $display("FAIL sat_scnt_end got=%0d want=255", bus.smp_cnt); end
        total++; if (bus.err_sticky !== 1'b1) begin bad++; $display("FAIL sat_err got=%b want=1", bus.err_sticky); end
        cycle(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_random();
        logic [15:0] s, c;
        logic [7:0]  x, y;
        bit v, w, clr;
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            w   = ($urandom_range(0, 4) == 0);
            clr = ($urandom_range(0, 29) == 0);
            gen(w, s, c, x, y);
            cycle(v, s, c, x, y, clr);
            total++; if (bus.out_valid !== m_ov) begin bad++; $display("FAIL rnd_ov i=%0d got=%b want=%b", i, bus.out_valid, m_ov); end
            if (m_ov) begin
                total++; if (bus.prod !== m_prod) begin bad++; $display("FAIL rnd_prod i=%0d got=%h want=%h", i, bus.prod, m_prod); end
                total++; if (bus.mismatch !== m_mm) begin bad++; $display("FAIL rnd_mm i=%0d got=%b want=%b", i, bus.mismatch, m_mm); end
            end
            total++; if ({bus.err_sticky, bus.err_cnt, bus.smp_cnt} !== {m_err, m_ecnt, m_scnt}) begin
                bad++; $display("FAIL rnd_book i=%0d got=%b/%0d/%0d want=%b/%0d/%0d", i,
                                bus.err_sticky, bus.err_cnt, bus.smp_cnt, m_err, m_ecnt, m_scnt);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] s, c;
        logic [7:0]  x, y;
        for (int i = 0; i < 3; i++) begin
            gen(i == 1, s, c, x, y);
            cycle(1, s, c, x, y, 0);
        end
        @(posedge CLK);
        #2;
        RST = 0;
        drive_idle();
        model_reset();
        #1;
        total++; if ({bus.out_valid, bus.prod, bus.mismatch, bus.err_sticky, bus.err_cnt, bus.smp_cnt} !== 35'h0) begin
            bad++; $display("FAIL arst_outs got=%b/%h/%b/%b/%0d/%0d want=all zero", bus.out_valid,
                            bus.prod, bus.mismatch, bus.err_sticky, bus.err_cnt, bus.smp_cnt);
        end
        @(negedge CLK);
        RST = 1;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0, 0, 0);
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL arst_idle_ov i=%0d got=%b want=0", i, bus.out_valid); end
        end
        cycle(1, 16'h000F, 16'h0000, 8'd3, 8'd5, 0);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL arst_lat1 got=%b want=0", bus.out_valid); end
        cycle(0, 0, 0, 0, 0, 0);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL arst_lat2 got=%b want=1", bus.out_valid); end
        total++; if (bus.prod !== 16'h000F) begin bad++; $display("FAIL arst_prod got=%h want=000f", bus.prod); end
        total++; if (bus.smp_cnt !== 8'd1) begin bad++; $display("FAIL arst_scnt got=%0d want=1", bus.smp_cnt); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_clear_priority();
        test_saturation();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
